// File: rtl/systolic_pkg.sv
// Shared types and default sizing for the systolic array serial input path.
package systolic_pkg;

  localparam int unsigned WIDTH           = 4;
  localparam int unsigned CHANNELS        = 4;
  localparam int unsigned WORDS_PER_BATCH = 8;
  localparam int unsigned FIFO_DEPTH      = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/serial_word_fifo.sv
// Small synchronous FIFO holding parallel word vectors ahead of serialisation.
module serial_word_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/systolic_serial_tx.sv
// Buffers parallel word vectors and emits them LSB-first on parallel 1-bit lanes,
// framed by a batch start pulse, per-word sync and a batch done pulse.
module systolic_serial_tx #(
  parameter int unsigned WIDTH           = systolic_pkg::WIDTH,
  parameter int unsigned CHANNELS        = systolic_pkg::CHANNELS,
  parameter int unsigned WORDS_PER_BATCH = systolic_pkg::WORDS_PER_BATCH,
  parameter int unsigned FIFO_DEPTH      = systolic_pkg::FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic                      data_valid,
  output logic                      data_ready,
  input  logic                      abort,
  output logic [CHANNELS-1:0]       bit_outputs,
  output logic                      start_out,
  output logic                      frame_sync,
  output logic                      busy,
  output logic                      done
);

  import systolic_pkg::*;

  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CW = $clog2(WORDS_PER_BATCH + 1);
  localparam int unsigned DW = CHANNELS * WIDTH;

  state_t           state;
  logic [BW-1:0]    bit_idx;
  logic [CW-1:0]    word_cnt;
  logic [WIDTH-1:0] shreg [CHANNELS];

  logic [DW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          last_bit;
  logic          last_word;

  assign data_ready = !fifo_full;
  assign push       = data_valid && !fifo_full;
  assign last_bit   = (bit_idx == BW'(WIDTH - 1));
  assign last_word  = (word_cnt == CW'(WORDS_PER_BATCH - 1));

  serial_word_fifo #(
    .DATA_W (DW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata (data_in),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    pop = 1'b0;
    if (!abort) begin
      case (state)
        START:   pop = 1'b1;
        SHIFT:   pop = last_bit && !last_word && !fifo_empty;
        GAP:     pop = !fifo_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  // Outputs are registered: each edge computes what the lanes show in the coming cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_idx     <= '0;
      word_cnt    <= '0;
      start_out   <= 1'b0;
      frame_sync  <= 1'b0;
      bit_outputs <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) shreg[c] <= '0;
    end else if (abort) begin
      state       <= IDLE;
      bit_idx     <= '0;
      word_cnt    <= '0;
      start_out   <= 1'b0;
      frame_sync  <= 1'b0;
      bit_outputs <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      for (int unsigned c = 0; c < CHANNELS; c++) shreg[c] <= '0;
    end else begin
      start_out   <= 1'b0;
      frame_sync  <= 1'b0;
      bit_outputs <= '0;
      done        <= 1'b0;

      // Every pop loads a fresh word and presents its bit 0 in the following cycle.
      if (pop) begin
        bit_idx    <= '0;
        frame_sync <= 1'b1;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          bit_outputs[c] <= head[c*WIDTH];
          shreg[c]       <= head[c*WIDTH +: WIDTH] >> 1;
        end
      end

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state     <= START;
            start_out <= 1'b1;
            busy      <= 1'b1;
          end
        end
        START: state <= SHIFT;
        SHIFT: begin
          if (!last_bit) begin
            bit_idx <= bit_idx + 1'b1;
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              bit_outputs[c] <= shreg[c][0];
              shreg[c]       <= shreg[c] >> 1;
            end
          end else begin
            word_cnt <= word_cnt + 1'b1;
            bit_idx  <= '0;
            if (last_word) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (fifo_empty) begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (!fifo_empty) state <= SHIFT;
        end
        DONE: begin
          word_cnt <= '0;
          state    <= IDLE;
          busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_serial_tx.sv
// Directed bench for systolic_serial_tx: a single-word-batch instance and a default instance.
module tb_systolic_serial_tx;

  localparam int W = 4;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [15:0] d1_data;
  logic        d1_valid, d1_ready, d1_abort, d1_start, d1_sync, d1_busy, d1_done;
  logic [3:0]  d1_bits;

  logic [15:0] data;
  logic        valid, ready, abort, start, sync, busy, done;
  logic [3:0]  bits;

  systolic_serial_tx #(.WORDS_PER_BATCH(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(d1_data), .data_valid(d1_valid),
    .data_ready(d1_ready), .abort(d1_abort), .bit_outputs(d1_bits),
    .start_out(d1_start), .frame_sync(d1_sync), .busy(d1_busy), .done(d1_done)
  );

  systolic_serial_tx dut8 (
    .clk(clk), .reset(reset), .data_in(data), .data_valid(valid),
    .data_ready(ready), .abort(abort), .bit_outputs(bits),
    .start_out(start), .frame_sync(sync), .busy(busy), .done(done)
  );

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] vecs [16];
  logic [3:0]  exp1 [4];

  // Receiver model for dut8: rebuilds words from the lanes using frame_sync.
  int          cyc = 0;
  int          k = W;
  logic [15:0] cur = '0;
  logic [15:0] rxq [$];
  int          start_cnt = 0, done_cnt = 0, sync_cnt = 0, gap_cycles = 0;
  int          start_cyc = 0, done_cyc = 0;
  bit          saw_not_ready = 1'b0;
  int          n_push = 0;

  always @(negedge clk) begin
    cyc++;
    if (start) begin start_cnt++; start_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!ready) saw_not_ready = 1'b1;
    if (!busy) k = W;
    if (sync) begin k = 0; sync_cnt++; end
    if (k < W) begin
      for (int ch = 0; ch < C; ch++) cur[ch*W+k] = bits[ch];
      k++;
      if (k == W) rxq.push_back(cur);
    end else if (busy && !start && !done) begin
      gap_cycles++;
      check("gap_bits", 32'(bits), 32'h0);
      check("gap_sync", 32'(sync), 32'h0);
    end
  end

  task automatic push8(input logic [15:0] v);
    data  = v;
    valid = 1'b1;
    for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
    check("push_ready", 32'(ready), 32'h1);
    @(negedge clk);
    valid = 1'b0;
    n_push++;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) @(negedge clk);
    check("done_wait", 32'(done_cnt), 32'(target));
  endtask

  task automatic run_batch(input int base, input string tag);
    int s0, d0, y0, g0, p0;
    s0 = start_cnt; d0 = done_cnt; y0 = sync_cnt; g0 = gap_cycles; p0 = n_push;
    rxq.delete();
    for (int i = 0; i < 8; i++) push8(vecs[base+i]);
    wait_done(d0 + 1);
    repeat (2) @(negedge clk);
    check({tag, "_starts"}, 32'(start_cnt - s0), 32'd1);
    check({tag, "_dones"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_span"}, 32'(done_cyc - start_cyc), 32'd33);
    check({tag, "_syncs"}, 32'(sync_cnt - y0), 32'd8);
    check({tag, "_gaps"}, 32'(gap_cycles - g0), 32'd0);
    check({tag, "_pushes"}, 32'(n_push - p0), 32'd8);
    check({tag, "_rxcount"}, 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8 && i < rxq.size(); i++) check({tag, "_word"}, 32'(rxq[i]), 32'(vecs[base+i]));
    check({tag, "_idle"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, g0, p0, n0;
    vecs = '{16'h1E2D, 16'h3C4B, 16'h5A69, 16'h7887, 16'h96A5, 16'hB4C3, 16'hD2E1, 16'hF00F,
             16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    exp1 = '{4'b0101, 4'b1001, 4'b0110, 4'b1010};
    d1_data = '0; d1_valid = 1'b0; d1_abort = 1'b0;
    data = '0; valid = 1'b0; abort = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'h1);
    check("rst_bits", 32'(bits), 32'h0);
    check("rst_start", 32'(start), 32'h0);
    check("rst_sync", 32'(sync), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst1_ready", 32'(d1_ready), 32'h1);
    reset = 1'b0;

    // Single-word batch on dut1, cycle by cycle.
    @(negedge clk);
    d1_data = 16'hA5C3; d1_valid = 1'b1;
    @(negedge clk);
    d1_valid = 1'b0;
    check("t1_pre_start", 32'(d1_start), 32'h0);
    @(negedge clk);
    check("t1_start", 32'(d1_start), 32'h1);
    check("t1_busy", 32'(d1_busy), 32'h1);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("t1_bits", 32'(d1_bits), 32'(exp1[b]));
      check("t1_sync", 32'(d1_sync), (b == 0) ? 32'h1 : 32'h0);
      check("t1_nostart", 32'(d1_start), 32'h0);
    end
    @(negedge clk);
    check("t1_done", 32'(d1_done), 32'h1);
    check("t1_done_bits", 32'(d1_bits), 32'h0);
    @(negedge clk);
    check("t1_done_end", 32'(d1_done), 32'h0);
    check("t1_idle", 32'(d1_busy), 32'h0);

    // Contiguous full batch.
    run_batch(0, "t2");

    // Starved batch: GAP cycles between word 3 and word 4.
    s0 = start_cnt; d0 = done_cnt; g0 = gap_cycles; p0 = n_push;
    rxq.delete();
    for (int i = 0; i < 3; i++) push8(vecs[8+i]);
    repeat (20) @(negedge clk);
    for (int i = 3; i < 8; i++) push8(vecs[8+i]);
    wait_done(d0 + 1);
    repeat (2) @(negedge clk);
    check("t3_gap_seen", 32'(gap_cycles > g0), 32'h1);
    check("t3_starts", 32'(start_cnt - s0), 32'd1);
    check("t3_dones", 32'(done_cnt - d0), 32'd1);
    check("t3_pushes", 32'(n_push - p0), 32'd8);
    check("t3_rxcount", 32'(rxq.size()), 32'd8);
    for (int i = 0; i < 8 && i < rxq.size(); i++) check("t3_word", 32'(rxq[i]), 32'(vecs[8+i]));

    // Back-pressure across two batches.
    saw_not_ready = 1'b0;
    s0 = start_cnt; d0 = done_cnt; p0 = n_push;
    rxq.delete();
    for (int i = 0; i < 16; i++) push8(vecs[i]);
    wait_done(d0 + 2);
    repeat (2) @(negedge clk);
    check("t4_ready_dropped", 32'(saw_not_ready), 32'h1);
    check("t4_starts", 32'(start_cnt - s0), 32'd2);
    check("t4_dones", 32'(done_cnt - d0), 32'd2);
    check("t4_pushes", 32'(n_push - p0), 32'd16);
    check("t4_rxcount", 32'(rxq.size()), 32'd16);
    for (int i = 0; i < 16 && i < rxq.size(); i++) check("t4_word", 32'(rxq[i]), 32'(vecs[i]));

    // Abort at word 3, bit 2, with a simultaneous push that must be dropped.
    s0 = start_cnt; d0 = done_cnt;
    for (int i = 0; i < 4; i++) push8(vecs[i]);
    n0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (start_cnt > s0 && cyc == start_cyc + 15) begin n0 = 1; break; end
    end
    check("t5_reach", 32'(n0), 32'h1);
    check("t5_bits_w3b2", 32'(bits), 32'b1001);
    abort = 1'b1; data = 16'hFFFF; valid = 1'b1;
    @(negedge clk); #1;
    abort = 1'b0; valid = 1'b0;
    check("t5_busy", 32'(busy), 32'h0);
    check("t5_bits", 32'(bits), 32'h0);
    check("t5_sync", 32'(sync), 32'h0);
    check("t5_ready", 32'(ready), 32'h1);
    check("t5_done", 32'(done), 32'h0);
    repeat (40) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_dropped", 32'(busy), 32'h0);
    s0 = start_cnt;
    rxq.delete();
    push8(vecs[5]);
    for (int i = 0; i < 20 && rxq.size() == 0; i++) @(negedge clk);
    check("t5_fresh_start", 32'(start_cnt - s0), 32'd1);
    check("t5_rxcount", 32'(rxq.size()), 32'd1);
    if (rxq.size() > 0) check("t5_word", 32'(rxq[0]), 32'(vecs[5]));

    // Asynchronous reset mid-SHIFT, then a clean batch.
    push8(vecs[6]);
    n0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sync) begin n0 = 1; break; end
    end
    check("t6_in_shift", 32'(n0), 32'h1);
    #1 reset = 1'b1;
    #1;
    check("t6_bits", 32'(bits), 32'h0);
    check("t6_sync", 32'(sync), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    check("t6_ready", 32'(ready), 32'h1);
    check("t6_start", 32'(start), 32'h0);
    check("t6_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_batch(8, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
